srl_init_checker: RTL and testbench
===================================

Name: srl_init_checker

Overview:
- Parametrised multi-channel self-checking shift-register tester; successor to the single SRL16 INIT test.
- Instantiates NUM_CH inferred SRL chains of length DEPTH (maps to SRL16E/SRLC32E) with per-channel INIT contents.
- Verifies the INIT bits shift out correctly after configuration, then verifies LFSR data delayed by DEPTH.
- Sticky per-channel error flags drive board LEDs in the test top; a fault-injection input lets benches prove the checker fires.

Parameters:
- NUM_CH, 8, number of channels, 1..16
- DEPTH, 16, shift length per channel, 2..32
- INIT, 32'h0000A5C3, base init word; bits [DEPTH-1:0] used
- SEED, 16'hACE1, LFSR seed; must be nonzero

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  shift enable; one shift and one compare per cycle while high
- inj  in  NUM_CH  fault inject: inverts channel i data-in bit on the current shift
- error  out  NUM_CH  sticky per-channel mismatch flags
- phase  out  2  0=INIT_CHK, 1=FLUSH, 2=RUN
- run  out  1  high when phase==RUN

Behaviour:
- Chain model, channel i: sr_i[DEPTH-1:0], power-up value INIT_i = INIT[DEPTH-1:0] rotated left by (i mod DEPTH). On a shift: sr_i <= {sr_i[DEPTH-2:0], d_i}; q_i = sr_i[DEPTH-1], combinational. sr_i has no reset.
- lfsr_a: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Advances every shift. d_i = lfsr_a[i] ^ inj[i].
- lfsr_b: identical polynomial and seed. Advances only on shifts with k >= DEPTH, so lfsr_b at shift k equals lfsr_a at shift k-DEPTH.
- Shift counter k, width $clog2(DEPTH+1): increments on each shift and saturates at DEPTH.
- Compare happens on each shift edge before the shift. exp_i = INIT_i[DEPTH-1-k] if k < DEPTH, else lfsr_b[i].
- error[i] <= error[i] | (q_i != exp_i) when the compare is enabled. Visible one cycle after the compare edge. Cleared only by rst.
- States:
  - INIT_CHK: bitstream-initial state; phase, k, LFSRs and errors take initial values with no rst required. Compare enabled. Goes to RUN when k reaches DEPTH.
  - FLUSH: entered asynchronously on rst. Compare disabled. Goes to RUN after DEPTH shifts.
  - RUN: compare enabled indefinitely.
- rst assertion: error=0, k=0, lfsr_a=lfsr_b=SEED, phase=FLUSH, all asynchronous. Chains keep their contents. While rst is high there are no shifts. The INIT_CHK phase never recurs after any rst.
- Reset values: error=0, phase=1 (FLUSH), run=0. Power-up values: error=0, phase=0, run=0.
- en=0: chains, LFSRs, k, phase and error all hold; no compare.
- Simultaneous inj and compare: the compare uses the pre-shift q, so inj affects only the new bit. A fault injected at shift k is detected at shift k+DEPTH, from either INIT_CHK or RUN.
- Multiple inj bits are independent per channel.
- rst released mid-FLUSH or mid-RUN restarts FLUSH from k=0.

Test Plan:
- Power-up, rst=0, en=1, defaults, 10000 ns: phase=0 for shifts 0..15, then run=1 at shift 16; error==0 throughout; q_0 sequence on shifts 0..15 = A5C3 MSB-first.
- inj[3] pulsed on shift 40 in RUN: error[3]=1 the cycle after shift 56; error stays 8'h08 and sticky; other bits 0.
- inj[0] on shift 2 (INIT_CHK): error=8'h01 after shift 18.
- en=0 for 5 cycles at shift 30: k, phase and error unchanged; compares resume with no false error; error==0 at 10000 ns.
- After error[3] is set, assert rst for 3 cycles mid-run: error=0 and phase=1 immediately (async); 16 shifts with no compare; then run=1 and error stays 0; INIT_CHK does not recur.
- Parameter sweep DEPTH=32, NUM_CH=16, INIT=32'hDEADBEEF; DEPTH=2, NUM_CH=1: clean run gives error==0; single inj on channel NUM_CH-1 gives only that bit set after DEPTH shifts.

Source files
------------

// File: rtl/srl_init_checker.sv
// rtl/srl_init_checker.sv - multi-channel SRL INIT and delayed-LFSR self-checker
// Chains carry no reset so they map onto SRL primitives; control state powers up in INIT_CHK.
module srl_init_checker #(
  parameter int          NUM_CH = 8,
  parameter int          DEPTH  = 16,
  parameter logic [31:0] INIT   = 32'h0000A5C3,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] inj,
  output logic [NUM_CH-1:0] error,
  output logic [1:0]        phase,
  output logic              run
);
  localparam int KW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [KW-1:0] K_MAX  = KW'(DEPTH);
  localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);

  typedef enum logic [1:0] {
    INIT_CHK = 2'd0,
    FLUSH    = 2'd1,
    RUN      = 2'd2
  } phase_e;

  function automatic logic [DEPTH-1:0] rot_init(input int r);
    logic [DEPTH-1:0] base;
    logic [DEPTH-1:0] res;
    base = INIT[DEPTH-1:0];
    res  = '0;
    for (int j = 0; j < DEPTH; j++) res[(j + r) % DEPTH] = base[j];
    return res;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Declaration values are the bitstream power-up state.
  phase_e            phase_q  = INIT_CHK;
  logic [KW-1:0]     k_q      = '0;
  logic [15:0]       lfsr_a_q = SEED;
  logic [15:0]       lfsr_b_q = SEED;
  logic [NUM_CH-1:0] error_q  = '0;
  logic              run_q    = 1'b0;

  phase_e            phase_d;
  logic [KW-1:0]     k_d;
  logic [15:0]       lfsr_a_d;
  logic [15:0]       lfsr_b_d;
  logic [NUM_CH-1:0] error_d;
  logic              run_d;

  logic              shift;
  logic              cmp_en;
  logic [NUM_CH-1:0] din;
  logic [NUM_CH-1:0] mis;

  assign shift  = en & ~rst;
  assign cmp_en = shift & (phase_q != FLUSH);
  assign din    = lfsr_a_q[NUM_CH-1:0] ^ inj;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [DEPTH-1:0] INIT_I = rot_init(i % DEPTH);

    logic [DEPTH-1:0] sr_q = INIT_I;
    logic [DEPTH-1:0] sr_d;
    logic [IW-1:0]    idx;
    logic             exp_bit;

    always_comb begin
      sr_d    = shift ? {sr_q[DEPTH-2:0], din[i]} : sr_q;
      idx     = IW'(K_LAST - k_q);
      exp_bit = (k_q < K_MAX) ? INIT_I[idx] : lfsr_b_q[i];
    end

    always_ff @(posedge clk) begin
      sr_q <= sr_d;
    end

    // Compare uses the pre-shift tap, so an injected bit only surfaces DEPTH shifts later.
    assign mis[i] = sr_q[DEPTH-1] ^ exp_bit;
  end

  always_comb begin
    phase_d  = phase_q;
    k_d      = k_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    error_d  = error_q;
    if (shift) begin
      lfsr_a_d = lfsr_next(lfsr_a_q);
      if (k_q == K_MAX) lfsr_b_d = lfsr_next(lfsr_b_q);
      else              k_d      = k_q + KW'(1);
      if (cmp_en) error_d = error_q | mis;
      if (k_d == K_MAX) phase_d = RUN;
    end
    run_d = (phase_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= FLUSH;
      k_q      <= '0;
      lfsr_a_q <= SEED;
      lfsr_b_q <= SEED;
      error_q  <= '0;
      run_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      k_q      <= k_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      error_q  <= error_d;
      run_q    <= run_d;
    end
  end

  assign error = error_q;
  assign phase = phase_q;
  assign run   = run_q;

endmodule

// File: tb/tb_srl_init_checker.sv
// tb/tb_srl_init_checker.sv - directed and randomized model-checked bench for srl_init_checker
// Three parameterisations run side by side against a history-based reference model.
module tb_srl_init_checker;
  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        en   = 1'b0;
  logic [7:0]  inj0 = '0;
  logic [15:0] inj1 = '0;
  logic [0:0]  inj2 = '0;
  logic [7:0]  err0;
  logic [15:0] err1;
  logic [0:0]  err2;
  logic [1:0]  ph0, ph1, ph2;
  logic        run0, run1, run2;

  always #5 clk = ~clk;

  srl_init_checker dut0 (
    .clk(clk), .rst(rst), .en(en), .inj(inj0), .error(err0), .phase(ph0), .run(run0)
  );
  srl_init_checker #(.NUM_CH(16), .DEPTH(32), .INIT(32'hDEADBEEF)) dut1 (
    .clk(clk), .rst(rst), .en(en), .inj(inj1), .error(err1), .phase(ph1), .run(run1)
  );
  srl_init_checker #(.NUM_CH(1), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .inj(inj2), .error(err2), .phase(ph2), .run(run2)
  );

  logic [15:0] obs_err [3];
  logic [1:0]  obs_ph  [3];
  logic        obs_run [3];
  always_comb begin
    obs_err[0] = {8'h00, err0};
    obs_err[1] = err1;
    obs_err[2] = {15'h0000, err2};
    obs_ph[0]  = ph0;
    obs_ph[1]  = ph1;
    obs_ph[2]  = ph2;
    obs_run[0] = run0;
    obs_run[1] = run1;
    obs_run[2] = run2;
  end

  int          NC [3] = '{8, 16, 1};
  int          DP [3] = '{16, 32, 2};
  logic [31:0] IV [3] = '{32'h0000A5C3, 32'hDEADBEEF, 32'h0000A5C3};

  logic [15:0] seq    [4096];
  logic [15:0] pushed [3][4096];
  int          m_cnt  [3];
  int          n_cnt  [3];
  bit          pwr    [3];
  logic [15:0] m_err  [3];

  int checks = 0;
  int errors = 0;

  function automatic bit init_bit(input int d, input int c, input int p);
    logic [31:0] w;
    int          src;
    w   = IV[d];
    src = (p - (c % DP[d]) + DP[d]) % DP[d];
    return w[src];
  endfunction

  function automatic logic [15:0] exp_phase(input int d);
    if (m_cnt[d] < DP[d]) return pwr[d] ? 16'd0 : 16'd1;
    return 16'd2;
  endfunction

  task automatic model_reset(input int d);
    m_err[d] = '0;
    m_cnt[d] = 0;
    pwr[d]   = 1'b0;
  endtask

  task automatic model_shift(input int d, input logic [15:0] injv);
    bit qb;
    bit eb;
    for (int c = 0; c < NC[d]; c++) begin
      qb = (n_cnt[d] < DP[d]) ? init_bit(d, c, DP[d] - 1 - n_cnt[d]) : pushed[d][n_cnt[d] - DP[d]][c];
      eb = (m_cnt[d] < DP[d]) ? init_bit(d, c, DP[d] - 1 - m_cnt[d]) : seq[m_cnt[d] - DP[d]][c];
      if (!(!pwr[d] && m_cnt[d] < DP[d]) && qb != eb) m_err[d][c] = 1'b1;
    end
    pushed[d][n_cnt[d]] = seq[m_cnt[d]] ^ injv;
    n_cnt[d]++;
    m_cnt[d]++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_err%0d", tag, d), obs_err[d], m_err[d]);
      chk($sformatf("%s_phase%0d", tag, d), 16'(obs_ph[d]), exp_phase(d));
      chk($sformatf("%s_run%0d", tag, d), 16'(obs_run[d]), 16'(exp_phase(d) == 16'd2));
    end
  endtask

  task automatic cycle(input bit e, input logic [15:0] i0, input logic [15:0] i1, input logic [15:0] i2);
    en   = e;
    inj0 = i0[7:0];
    inj1 = i1;
    inj2 = i2[0:0];
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst)    model_reset(d);
      else if (e) model_shift(d, (d == 0) ? i0 : (d == 1) ? i1 : i2);
    end
    #1;
    check_all("cycle");
    inj0 = '0;
    inj1 = '0;
    inj2 = '0;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) model_reset(d);
    check_all("rst_async");
    chk("rst_err0", obs_err[0], 16'h0000);
    chk("rst_phase0", 16'(obs_ph[0]), 16'd1);
    repeat (ncyc) cycle(1'b1, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    logic [15:0] fb;
    logic [15:0] i0, i1, i2;
    s = 16'hACE1;
    for (int j = 0; j < 4096; j++) begin
      seq[j] = s;
      fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
      s  = (s >> 1) | (fb << 15);
    end
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = 0;
      n_cnt[d] = 0;
      pwr[d]   = 1'b1;
      m_err[d] = '0;
    end

    #1;
    check_all("powerup");

    // Power-up INIT_CHK with a fault on channel 0 at shift 2.
    while (m_cnt[0] < 40) begin
      cycle(1'b1, (m_cnt[0] == 2) ? 16'h0001 : 16'h0000, 16'h0, 16'h0);
      if (m_cnt[0] == 15) chk("init_phase", 16'(obs_ph[0]), 16'd0);
      if (m_cnt[0] == 16) chk("run_at_16", 16'(obs_run[0]), 16'd1);
      if (m_cnt[0] == 18) chk("inj0_pre", obs_err[0], 16'h0000);
      if (m_cnt[0] == 19) chk("inj0_det", obs_err[0], 16'h0001);
    end

    do_reset(3);

    while (m_cnt[0] < 30) cycle(1'b1, 16'h0, 16'h0, 16'h0);
    repeat (5) cycle(1'b0, 16'h0, 16'h0, 16'h0);
    chk("pause_phase", 16'(obs_ph[0]), 16'd2);
    chk("pause_err", obs_err[0], 16'h0000);

    while (m_cnt[0] < 90) begin
      i0 = (m_cnt[0] == 40) ? 16'h0008 : 16'h0000;
      i1 = (m_cnt[0] == 50) ? 16'h8000 : 16'h0000;
      i2 = (m_cnt[0] == 50) ? 16'h0001 : 16'h0000;
      cycle(1'b1, i0, i1, i2);
      if (m_cnt[0] == 56) chk("inj3_pre", obs_err[0], 16'h0000);
      if (m_cnt[0] == 57) chk("inj3_det", obs_err[0], 16'h0008);
    end
    chk("inj3_sticky", obs_err[0], 16'h0008);
    chk("sweep32_inj", obs_err[1], 16'h8000);
    chk("sweep2_inj", obs_err[2], 16'h0001);

    do_reset(3);
    while (m_cnt[0] < 40) cycle(1'b1, 16'h0, 16'h0, 16'h0);
    chk("clean_err0", obs_err[0], 16'h0000);
    chk("clean_err1", obs_err[1], 16'h0000);
    chk("clean_run0", 16'(obs_run[0]), 16'd1);

    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(99) == 0) do_reset(int'($urandom_range(3, 1)));
      i0 = ($urandom_range(49) == 0) ? 16'(16'h0001 << $urandom_range(7))  : 16'h0000;
      i1 = ($urandom_range(49) == 0) ? 16'(16'h0001 << $urandom_range(15)) : 16'h0000;
      i2 = ($urandom_range(49) == 0) ? 16'h0001 : 16'h0000;
      cycle($urandom_range(9) != 0, i0, i1, i2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
